// File: rtl/toss_pkg.sv
// Shared types and constants for the coin-toss streak detection blocks.
package toss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_RUN_LEN = 3;
    localparam int DEF_CNT_W   = 8;

    // Width of a channel index; never below one bit.
    function automatic int ch_idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating pointer.
module rr_arbiter
    import toss_pkg::*;
#(
    parameter int N = DEF_NUM_CH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int IW = ch_idx_w(N);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] ptr_nxt_s;
    logic [IW-1:0] sel_s;
    logic [N-1:0]  grant_s;
    logic          found_s;
    int            sel_v;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        grant_s   = '0;
        found_s   = 1'b0;
        ptr_nxt_s = ptr_r;
        sel_v     = 0;
        sel_s     = '0;
        for (int k = 0; k < N; k++) begin
            sel_v = (int'(ptr_r) + k) % N;
            sel_s = IW'(sel_v);
            if (enable && !found_s && req[sel_s]) begin
                grant_s[sel_s] = 1'b1;
                found_s        = 1'b1;
                ptr_nxt_s      = IW'((sel_v + 1) % N);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;

    // Pointer only moves when a grant is issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/toss_stream_scheduler.sv
// Shared consecutive-heads detector: arbitrates NUM_CH toss sources and keeps
// per-channel run lengths, streak levels and a saturating streak-start count.
module toss_stream_scheduler
    import toss_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_enable,
    input  logic                        cfg_clear,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH-1:0]           req_toss,
    output logic [NUM_CH-1:0]           req_ready,
    output logic [NUM_CH-1:0]           det_level,
    output logic                        det_pulse,
    output logic [ch_idx_w(NUM_CH)-1:0] det_ch,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic                        busy
);

    localparam int IW = ch_idx_w(NUM_CH);
    localparam int RW = $clog2(RUN_LEN + 1);

    ctrl_state_t       state_r;
    ctrl_state_t       state_nxt_s;
    logic              arb_en_s;
    logic              clear_s;
    logic [NUM_CH-1:0] grant_s;
    logic [NUM_CH-1:0] accept_s;
    logic [NUM_CH-1:0] start_s;
    logic [NUM_CH-1:0] level_nxt_s;
    logic [IW-1:0]     start_idx_s;
    logic [NUM_CH-1:0] det_level_r;
    logic              det_pulse_r;
    logic [IW-1:0]     det_ch_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic              busy_r;

    // Controller state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next state; a clear request overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (cfg_clear) begin
            state_nxt_s = CLEAR;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_enable) state_nxt_s = RUN;
                    else            state_nxt_s = IDLE;
                end
                RUN: begin
                    if (cfg_enable) state_nxt_s = RUN;
                    else            state_nxt_s = IDLE;
                end
                CLEAR: begin
                    if (cfg_enable) state_nxt_s = RUN;
                    else            state_nxt_s = IDLE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // The clear pulse wins over any same-cycle request.
    assign arb_en_s = (state_r == RUN) && !cfg_clear;
    assign clear_s  = cfg_clear || (state_r == CLEAR);

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (arb_en_s),
        .req    (req_valid),
        .grant  (grant_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = req_valid & grant_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [RW-1:0] run_r;
        logic [RW-1:0] run_nxt;
        logic          start;

        // Run length update; a head on the last step below RUN_LEN starts a streak.
        always_comb begin
            run_nxt = run_r;
            start   = 1'b0;
            if (clear_s) begin
                run_nxt = '0;
            end else if (accept_s[g]) begin
                if (req_toss[g]) begin
                    if (run_r == RW'(RUN_LEN - 1)) start = 1'b1;
                    else                           start = 1'b0;
                    if (run_r != RW'(RUN_LEN)) run_nxt = run_r + RW'(1);
                    else                       run_nxt = run_r;
                end else begin
                    run_nxt = '0;
                end
            end else begin
                run_nxt = run_r;
            end
        end

        // Per-channel run length storage.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                run_r <= '0;
            end else begin
                run_r <= run_nxt;
            end
        end

        assign start_s[g]     = start;
        assign level_nxt_s[g] = (run_nxt >= RW'(RUN_LEN));
    end

    // At most one channel is accepted per cycle, so at most one start bit is set.
    always_comb begin
        start_idx_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (start_s[k]) start_idx_s = IW'(k);
            else            start_idx_s = start_idx_s;
        end
    end

    // Registered detection outputs and saturating streak counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            det_level_r <= '0;
            det_pulse_r <= 1'b0;
            det_ch_r    <= '0;
            hit_cnt_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s == RUN);
            det_level_r <= level_nxt_s;
            if (clear_s) begin
                det_pulse_r <= 1'b0;
                hit_cnt_r   <= '0;
            end else begin
                det_pulse_r <= |start_s;
                if (|start_s) begin
                    det_ch_r <= start_idx_s;
                    if (hit_cnt_r != {CNT_W{1'b1}}) begin
                        hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign det_level = det_level_r;
    assign det_pulse = det_pulse_r;
    assign det_ch    = det_ch_r;
    assign hit_cnt   = hit_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_toss_stream_scheduler.sv
// Directed self-checking bench for toss_stream_scheduler (default instance plus
// a RUN_LEN=1, CNT_W=2 instance for single-head streaks and counter saturation).
module tb_toss_stream_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_enable, cfg_clear;
    logic [3:0] req_valid, req_toss, req_ready, det_level;
    logic       det_pulse;
    logic [1:0] det_ch;
    logic [7:0] hit_cnt;
    logic       busy;

    logic       s_enable, s_clear;
    logic [1:0] s_valid, s_toss, s_ready, s_level;
    logic       s_pulse;
    logic [0:0] s_ch;
    logic [1:0] s_hit;
    logic       s_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    toss_stream_scheduler #(.NUM_CH(4), .RUN_LEN(3), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
        .req_valid(req_valid), .req_toss(req_toss), .req_ready(req_ready),
        .det_level(det_level), .det_pulse(det_pulse), .det_ch(det_ch),
        .hit_cnt(hit_cnt), .busy(busy)
    );

    toss_stream_scheduler #(.NUM_CH(2), .RUN_LEN(1), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .cfg_enable(s_enable), .cfg_clear(s_clear),
        .req_valid(s_valid), .req_toss(s_toss), .req_ready(s_ready),
        .det_level(s_level), .det_pulse(s_pulse), .det_ch(s_ch),
        .hit_cnt(s_hit), .busy(s_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_enable = 1'b0; cfg_clear = 1'b0;
        req_valid = 4'hF; req_toss = 4'hF;
        s_enable = 1'b0; s_clear = 1'b0; s_valid = 2'b00; s_toss = 2'b00;
        #12;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (det_level !== 4'b0000) begin errors++; $display("FAIL reset_level got=%b exp=0000", det_level); end
        checks++; if (det_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", det_pulse); end
        checks++; if (det_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", det_ch); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit got=%0d exp=0", hit_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0; req_valid = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        int         cnt[4];
        int         hits;
        logic [3:0] exp_rdy, exp_lvl;
        logic       exp_pulse;
        cnt = '{0, 0, 0, 0};
        hits = 0;
        cfg_enable = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy got=%b exp=1", busy); end
        req_valid = 4'hF; req_toss = 4'hF;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
            tick();
            cnt[k % 4]++;
            exp_pulse = (cnt[k % 4] == 3);
            if (exp_pulse) hits++;
            for (int c = 0; c < 4; c++) exp_lvl[c] = (cnt[c] >= 3);
            checks++; if (det_level !== exp_lvl) begin errors++; $display("FAIL rr_level k=%0d got=%b exp=%b", k, det_level, exp_lvl); end
            checks++; if (det_pulse !== exp_pulse) begin errors++; $display("FAIL rr_pulse k=%0d got=%b exp=%b", k, det_pulse, exp_pulse); end
            checks++; if (hit_cnt !== 8'(hits)) begin errors++; $display("FAIL rr_hit k=%0d got=%0d exp=%0d", k, hit_cnt, hits); end
            if (exp_pulse) begin
                checks++; if (det_ch !== 2'(k % 4)) begin errors++; $display("FAIL rr_ch k=%0d got=%0d exp=%0d", k, det_ch, k % 4); end
            end
        end
        req_valid = 4'h0;
        checks++; if (hit_cnt !== 8'd4) begin errors++; $display("FAIL rr_hit_total got=%0d exp=4", hit_cnt); end
    endtask

    task automatic test_clear_priority();
        req_valid = 4'b0010; req_toss = 4'b0010; cfg_clear = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_ready got=%b exp=0000", req_ready); end
        tick();
        cfg_clear = 1'b0;
        checks++; if (det_level !== 4'b0000) begin errors++; $display("FAIL clr_level got=%b exp=0000", det_level); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL clr_hit got=%0d exp=0", hit_cnt); end
        checks++; if (det_pulse !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b exp=0", det_pulse); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_state_ready got=%b exp=0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL clr_resume_ready got=%b exp=0010", req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (det_pulse !== (k == 2)) begin errors++; $display("FAIL clr_head_pulse k=%0d got=%b", k, det_pulse); end
        end
        req_valid = 4'h0;
        checks++; if (det_level !== 4'b0010) begin errors++; $display("FAIL clr_relevel got=%b exp=0010", det_level); end
        checks++; if (det_ch !== 2'd1) begin errors++; $display("FAIL clr_ch got=%0d exp=1", det_ch); end
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL clr_rehit got=%0d exp=1", hit_cnt); end
    endtask

    task automatic test_single_streak();
        req_valid = 4'b0001; req_toss = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ss_ready got=%b exp=0001", req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (det_level[0] !== (k == 2)) begin errors++; $display("FAIL ss_level k=%0d got=%b", k, det_level[0]); end
            checks++; if (det_pulse !== (k == 2)) begin errors++; $display("FAIL ss_pulse k=%0d got=%b", k, det_pulse); end
        end
        req_valid = 4'h0;
        checks++; if (det_ch !== 2'd0) begin errors++; $display("FAIL ss_ch got=%0d exp=0", det_ch); end
        checks++; if (hit_cnt !== 8'd2) begin errors++; $display("FAIL ss_hit got=%0d exp=2", hit_cnt); end
        tick();
        checks++; if (det_pulse !== 1'b0) begin errors++; $display("FAIL ss_pulse_drop got=%b exp=0", det_pulse); end
        checks++; if (det_level !== 4'b0011) begin errors++; $display("FAIL ss_level_hold got=%b exp=0011", det_level); end
    endtask

    task automatic test_pattern();
        logic seq[7];
        logic [3:0] exp_lvl;
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            req_valid = 4'b0100;
            req_toss  = {1'b0, seq[k], 2'b00};
            #1;
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL pat_ready k=%0d got=%b exp=0100", k, req_ready); end
            tick();
            exp_lvl = {1'b0, (k >= 5), 2'b11};
            checks++; if (det_pulse !== (k == 5)) begin errors++; $display("FAIL pat_pulse k=%0d got=%b", k, det_pulse); end
            checks++; if (det_level !== exp_lvl) begin errors++; $display("FAIL pat_level k=%0d got=%b exp=%b", k, det_level, exp_lvl); end
        end
        req_valid = 4'h0;
        checks++; if (hit_cnt !== 8'd3) begin errors++; $display("FAIL pat_hit got=%0d exp=3", hit_cnt); end
        tick();
        checks++; if (det_ch !== 2'd2) begin errors++; $display("FAIL pat_ch_hold got=%0d exp=2", det_ch); end
    endtask

    task automatic test_disable();
        req_valid = 4'b0011; req_toss = 4'b0000; cfg_enable = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL dis_last_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL dis_ready k=%0d got=%b exp=0000", k, req_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy k=%0d got=%b exp=0", k, busy); end
            tick();
        end
        cfg_enable = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL dis_resume got=%b exp=0010", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dis_busy_back got=%b exp=1", busy); end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0001; req_toss = 4'b0001;
        tick(); tick(); tick();
        checks++; if (hit_cnt !== 8'd4) begin errors++; $display("FAIL ar_pre_hit got=%0d exp=4", hit_cnt); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (det_level !== 4'b0000) begin errors++; $display("FAIL ar_level got=%b exp=0000", det_level); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL ar_hit got=%0d exp=0", hit_cnt); end
        checks++; if (det_pulse !== 1'b0) begin errors++; $display("FAIL ar_pulse got=%b exp=0", det_pulse); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready got=%b exp=0000", req_ready); end
        reset = 1'b0; req_valid = 4'h0; cfg_enable = 1'b0;
        tick();
    endtask

    task automatic test_runlen1_saturate();
        logic       seq[10];
        logic       exp_p[10];
        logic [1:0] exp_h[10];
        seq   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_h = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        s_enable = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            s_valid = 2'b01;
            s_toss  = {1'b0, seq[k]};
            tick();
            checks++; if (s_pulse !== exp_p[k]) begin errors++; $display("FAIL sat_pulse k=%0d got=%b exp=%b", k, s_pulse, exp_p[k]); end
            checks++; if (s_hit !== exp_h[k]) begin errors++; $display("FAIL sat_hit k=%0d got=%0d exp=%0d", k, s_hit, exp_h[k]); end
            checks++; if (s_level[0] !== seq[k]) begin errors++; $display("FAIL sat_level k=%0d got=%b exp=%b", k, s_level[0], seq[k]); end
        end
        s_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_clear_priority();
        test_single_streak();
        test_pattern();
        test_disable();
        test_async_reset();
        test_runlen1_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
